out_port_scheduler: RTL

Sequences processor OUT-instruction writes onto the four 8-bit external output ports. Each processor write (port select plus data) is queued in a small FIFO, then delivered to the addressed port with a per-port strobe/acknowledge handshake toward the external world. The block sits between the processor datapath (`ALUout`, `OUTportWrite`) and the `OutExtWorld1..4` pins. It decouples single-cycle processor writes from slow external consumers.

---
 rtl/out_port_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/out_port_scheduler.sv
// out_port_scheduler
//   Queues processor OUT-instruction writes ({PortSel, ALUout}) in a small FIFO
//   and delivers each one to its 8-bit external port with a strobe/ack handshake.
//
// Parameters
//   DEPTH   : FIFO entries (power of two, >= 2)
//   TIMEOUT : no-ack cycles tolerated in WAIT_ACK (timeout build only)
//
// Ports
//   clk, Reset            : rising-edge clock, synchronous active-high reset
//   OUTportWrite, PortSel,
//   ALUout                : processor write request, target port, data
//   Stall                 : FIFO full, processor must hold off
//   OutExtWorld1..4       : registered port data, hold last value
//   OutStrobe / OutAck    : per-port one-hot strobe and acknowledge
//   Busy                  : FIFO non-empty or transfer pending
//   Overflow              : sticky, write attempted while full
//   TimeoutErr            : sticky, transfer abandoned (0 without timeout build)
//
// Build option
//   OUT_SCHED_TIMEOUT_EN  : when defined, a transfer with no ack for TIMEOUT
//                           WAIT_ACK cycles is abandoned and TimeoutErr set.
//
// State | Meaning
// IDLE     | no transfer pending; loads the FIFO head when one is queued
// WAIT_ACK | strobe high on the latched port, waiting for its ack
module out_port_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       OUTportWrite,
  input  logic [1:0] PortSel,
  input  logic [7:0] ALUout,
  output logic       Stall,
  output logic [7:0] OutExtWorld1,
  output logic [7:0] OutExtWorld2,
  output logic [7:0] OutExtWorld3,
  output logic [7:0] OutExtWorld4,
  output logic [3:0] OutStrobe,
  input  logic [3:0] OutAck,
  output logic       Busy,
  output logic       Overflow,
  output logic       TimeoutErr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [7:0]    r_port [4];
  logic [3:0]    r_strobe;
  logic [1:0]    r_sel;
  logic          r_timeout_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head_sel;
  logic [7:0]    w_head_data;

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = OUTportWrite && !w_full;
  assign w_pop       = (r_state == IDLE) && !w_empty;
  assign w_head_sel  = r_mem[r_rd_ptr][9:8];
  assign w_head_data = r_mem[r_rd_ptr][7:0];

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {PortSel, ALUout};
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // Fullness is judged on the registered count, so a pop in the same
      // cycle does not rescue a write that arrives while full.
      if (OUTportWrite && w_full) r_overflow <= 1'b1;
    end
  end

`ifdef OUT_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] r_tcnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_port[0]     <= '0;
      r_port[1]     <= '0;
      r_port[2]     <= '0;
      r_port[3]     <= '0;
      r_strobe      <= '0;
      r_sel         <= '0;
      r_timeout_err <= 1'b0;
`ifdef OUT_SCHED_TIMEOUT_EN
      r_tcnt        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_port[w_head_sel] <= w_head_data;
            r_strobe           <= 4'b0001 << w_head_sel;
            r_sel              <= w_head_sel;
`ifdef OUT_SCHED_TIMEOUT_EN
            r_tcnt             <= '0;
`endif
            r_state            <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (OutAck[r_sel]) begin
            r_strobe <= '0;
            r_state  <= IDLE;
          end
`ifdef OUT_SCHED_TIMEOUT_EN
          // r_tcnt holds the no-ack cycles already seen, so TIMEOUT-1 here
          // means this cycle is the TIMEOUT-th one without an ack.
          else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_strobe      <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Stall        = w_full;
  assign Busy         = !w_empty || (r_state != IDLE);
  assign Overflow     = r_overflow;
  assign TimeoutErr   = r_timeout_err;
  assign OutStrobe    = r_strobe;
  assign OutExtWorld1 = r_port[0];
  assign OutExtWorld2 = r_port[1];
  assign OutExtWorld3 = r_port[2];
  assign OutExtWorld4 = r_port[3];

endmodule
